fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 StallF  input  1  hold PC and fetch buffer (from hazard unit).
REQ-005 StallD  input  1  hold IF/ID outputs (from hazard unit).
REQ-006 PCSrcD  input  1  taken branch resolved in decode; ignored while StallD=1.
REQ-007 PCBranchD  input  32  branch target.
REQ-008 inst_req  output  1  one-cycle instruction-memory request pulse.
REQ-009 inst_addr  output  32  request address, equal to PCF.
REQ-010 inst_rdata  input  32  returned instruction word.
REQ-011 inst_data_ok  input  1  inst_rdata valid this cycle; arrives ≥1 cycle after inst_req.
REQ-012 PCF  output  32  current fetch PC.
REQ-013 InstrD  output  32  IF/ID instruction.
REQ-014 PCPlus4D  output  32  IF/ID PC+4.
REQ-015 ValidD  output  1  IF/ID holds a real instruction (0 = bubble).
REQ-016 FetchBusy  output  1  high in S_REQ and S_WAIT (no instruction ready).

Function
REQ-017 FSM states S_REQ, S_WAIT, S_FULL; one request outstanding max.
REQ-018 S_REQ: inst_req=1, inst_addr=PCF; next state S_WAIT unconditionally.
REQ-019 S_WAIT: inst_data_ok=1 and kill=0 -> capture inst_rdata into buffer, go S_FULL; inst_data_ok=1 and kill=1 -> discard data, clear kill, go S_REQ; else stay.
REQ-020 S_FULL: deliver when StallF=0, StallD=0, and no redirect; delivery loads InstrD=buffer, PCPlus4D=PCF+4, ValidD=1; PCF<=PCF+4; go S_REQ.
REQ-021 S_FULL with StallF=1 or StallD=1: PCF, buffer, state, and IF/ID outputs hold.
REQ-022 StallD=0 and no delivery this cycle -> IF/ID loads bubble: InstrD=0, PCPlus4D=0, ValidD=0.
REQ-023 StallD=1 -> IF/ID outputs hold regardless of state.
REQ-024 Redirect = PCSrcD & ~StallD; takes priority over delivery and StallF; PCF<=PCBranchD; IF/ID loads bubble.
REQ-025 Redirect in S_REQ -> request with old PC still issues; set kill; go S_WAIT.
REQ-026 Redirect in S_WAIT without inst_data_ok -> set kill, stay.
REQ-026a Redirect in S_WAIT with inst_data_ok the same cycle -> drop data; go S_REQ with kill=0.
REQ-027 Redirect in S_FULL -> drop buffer; go S_REQ.
REQ-028 PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0.
REQ-029 inst_data_ok is ignored outside S_WAIT.
REQ-030 Latency: data_ok at cycle t -> InstrD valid at t+2 earliest (capture at t, deliver at t+1 edge).

Reset
REQ-031 While rst=1: inst_req=0; state<=S_REQ; PCF<=RESET_PC; kill<=0; buffer<=0; InstrD<=0; PCPlus4D<=0; ValidD<=0.
REQ-032 First request at RESET_PC occurs in the first cycle after rst deasserts.
REQ-033 Reset asserted mid-request -> outstanding response is ignored; next request after reset is RESET_PC.

Verification
REQ-034 Reset, memory latency 1, no stalls -> inst_addr sequence 0,4,8; ValidD pulses with PCPlus4D=4,8,12.
REQ-035 S_FULL with buffer 32'h2408_0005, StallF=StallD=1 for 3 cycles -> InstrD, PCF, and ValidD unchanged; delivered on the first cycle after release.
REQ-036 S_WAIT at PCF=0x10, PCSrcD=1, PCBranchD=0x40, data_ok 2 cycles later -> data dropped, next inst_addr=0x40, ValidD=0 throughout.
REQ-037 PCSrcD=1 with StallD=1 -> no redirect; PCF unchanged.
REQ-038 RESET_PC=32'hFFFF_FFFC -> first delivery gives PCPlus4D=0; next inst_addr=0.
REQ-039 rst asserted while in S_WAIT, data_ok arrives during rst -> ValidD stays 0; post-reset inst_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one instruction-memory request at a time,
// buffers the returned word and hands it to the IF/ID register under hazard control.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        PCSrcD,
  input  logic [31:0] PCBranchD,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_rdata,
  input  logic        inst_data_ok,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        FetchBusy
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;

  logic [1:0]  state, state_n;
  logic        kill, kill_n;
  logic [31:0] pc_n;
  logic [31:0] buffer, buffer_n;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic        deliver;

  // A redirect from decode only counts when decode itself is not stalled.
  assign redirect  = PCSrcD & ~StallD;
  assign deliver   = (state == S_FULL) & ~StallF & ~StallD & ~redirect;
  assign pc_plus4  = PCF + 32'd4;

  assign inst_req  = ~rst & (state == S_REQ);
  assign inst_addr = PCF;
  assign FetchBusy = (state != S_FULL);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_n  = state;
    kill_n   = kill;
    pc_n     = PCF;
    buffer_n = buffer;

    case (state)
      S_REQ: begin
        // The request for the old PC still goes out; a redirect only marks its reply as stale.
        state_n = S_WAIT;
        kill_n  = redirect;
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          if (kill | redirect) begin
            kill_n  = 1'b0;
            state_n = S_REQ;
          end else begin
            buffer_n = inst_rdata;
            state_n  = S_FULL;
          end
        end else if (redirect) begin
          kill_n = 1'b1;
        end
      end
      S_FULL: begin
        if (redirect || deliver) begin
          state_n = S_REQ;
        end
      end
      default: begin
        state_n = S_REQ;
        kill_n  = 1'b0;
      end
    endcase

    if (redirect) begin
      pc_n = PCBranchD;
    end else if (deliver) begin
      pc_n = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    if (rst) begin
      state    <= S_REQ;
      kill     <= 1'b0;
      PCF      <= RESET_PC;
      buffer   <= 32'h0;
      InstrD   <= 32'h0;
      PCPlus4D <= 32'h0;
      ValidD   <= 1'b0;
    end else begin
      state  <= state_n;
      kill   <= kill_n;
      PCF    <= pc_n;
      buffer <= buffer_n;
      // IF/ID holds under StallD; otherwise it takes the delivered word or a bubble.
      if (!StallD) begin
        if (deliver) begin
          InstrD   <= buffer;
          PCPlus4D <= pc_plus4;
          ValidD   <= 1'b1;
        end else begin
          InstrD   <= 32'h0;
          PCPlus4D <= 32'h0;
          ValidD   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a flag-based fetch model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fetch_stage;

  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        StallF = 1'b0;
  logic        StallD = 1'b0;
  logic        PCSrcD = 1'b0;
  logic [31:0] PCBranchD = 32'h0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = 32'h0;
  logic [31:0] w_rdata = 32'h0;

  logic        inst_req, ValidD, FetchBusy;
  logic [31:0] inst_addr, PCF, InstrD, PCPlus4D;
  logic        w_req, w_valid, w_busy;
  logic [31:0] w_addr, w_pcf, w_instr, w_pc4;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .PCSrcD(PCSrcD),
    .PCBranchD(PCBranchD), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok), .PCF(PCF),
    .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD), .FetchBusy(FetchBusy)
  );

  fetch_stage #(.RESET_PC(WRAP_PC)) dut_wrap (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .PCSrcD(PCSrcD),
    .PCBranchD(PCBranchD), .inst_req(w_req), .inst_addr(w_addr),
    .inst_rdata(w_rdata), .inst_data_ok(inst_data_ok), .PCF(w_pcf),
    .InstrD(w_instr), .PCPlus4D(w_pc4), .ValidD(w_valid), .FetchBusy(w_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] imem(input logic [31:0] a);
    return 32'h2408_0005 + (a << 8);
  endfunction

  // Memory: a request seen in cycle c answers in cycle c+lat.
  typedef struct {
    int          due;
    logic [31:0] a;
    logic [31:0] aw;
  } rsp_t;
  rsp_t mem_q[$];
  int   cyc = 0;
  int   lat = 1;

  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
      inst_data_ok = 1'b1;
      inst_rdata   = imem(mem_q[0].a);
      w_rdata      = imem(mem_q[0].aw);
      void'(mem_q.pop_front());
    end else begin
      inst_data_ok = 1'b0;
      inst_rdata   = 32'hDEAD_BEEF;
      w_rdata      = 32'hDEAD_BEEF;
    end
  end

  // Behavioural model: fetch PC, "request in flight", "reply is stale", "word waiting".
  logic [31:0] m_pc, m_buf, m_instr, m_pc4;
  logic        m_wait, m_kill, m_full, m_valid;
  bit          model_ready = 0;
  logic        prev_rst = 1'b1;
  int          rel_cyc = 0;
  logic [31:0] addr_log[$];
  logic [31:0] w_addr_log[$];
  logic [31:0] vld_pc4[$];
  int          vld_cyc[$];
  logic [31:0] w_pc4_log[$];

  initial forever begin
    logic redir, give, exp_req;
    @(negedge clk);
    if (inst_req === 1'b1) mem_q.push_back('{cyc + lat, inst_addr, w_addr});
    if (prev_rst && !rst) rel_cyc = cyc;
    prev_rst = rst;

    if (model_ready) begin
      exp_req = !rst && !m_wait && !m_full;
      check("inst_req",  32'(inst_req),  32'(exp_req));
      check("inst_addr", inst_addr,      m_pc);
      check("PCF",       PCF,            m_pc);
      check("FetchBusy", 32'(FetchBusy), 32'(!m_full));
      check("InstrD",    InstrD,         m_instr);
      check("PCPlus4D",  PCPlus4D,       m_pc4);
      check("ValidD",    32'(ValidD),    32'(m_valid));
      check("wrap_req",  32'(w_req),     32'(exp_req));
      check("wrap_busy", 32'(w_busy),    32'(!m_full));
      check("wrap_vld",  32'(w_valid),   32'(m_valid));
      if (!rst) begin
        if (inst_req === 1'b1) addr_log.push_back(inst_addr);
        if (w_req === 1'b1) w_addr_log.push_back(w_addr);
        if (ValidD === 1'b1) begin
          vld_pc4.push_back(PCPlus4D);
          vld_cyc.push_back(cyc);
        end
        if (w_valid === 1'b1) w_pc4_log.push_back(w_pc4);
      end
    end

    if (rst) begin
      m_pc = 32'h0; m_buf = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
      m_wait = 1'b0; m_kill = 1'b0; m_full = 1'b0; m_valid = 1'b0;
      model_ready = 1;
    end else begin
      redir = PCSrcD && !StallD;
      give  = m_full && !StallF && !StallD && !redir;
      if (!StallD) begin
        m_instr = give ? m_buf : 32'h0;
        m_pc4   = give ? m_pc + 32'd4 : 32'h0;
        m_valid = give;
      end
      if (redir) begin
        if (!m_wait && !m_full) begin
          m_wait = 1'b1;
          m_kill = 1'b1;
        end else if (m_wait) begin
          if (inst_data_ok) begin
            m_wait = 1'b0;
            m_kill = 1'b0;
          end else begin
            m_kill = 1'b1;
          end
        end else begin
          m_full = 1'b0;
        end
        m_pc = PCBranchD;
      end else if (give) begin
        m_full = 1'b0;
        m_pc   = m_pc + 32'd4;
      end else if (!m_wait && !m_full) begin
        m_wait = 1'b1;
      end else if (m_wait && inst_data_ok) begin
        m_wait = 1'b0;
        if (m_kill) begin
          m_kill = 1'b0;
        end else begin
          m_full = 1'b1;
          m_buf  = imem(m_pc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; StallF = 1'b0; StallD = 1'b0; PCSrcD = 1'b0; PCBranchD = 32'h0;
    repeat (4) step();
    addr_log.delete(); w_addr_log.delete(); vld_pc4.delete(); vld_cyc.delete(); w_pc4_log.delete();
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (ValidD !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    check(name, 32'(ValidD), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // A: straight-line fetch at latency 1, plus the wrap-around instance.
    lat = 1;
    do_reset();
    rst = 1'b0;
    #1;
    check("A_first_req",  32'(inst_req), 32'd1);
    check("A_first_addr", inst_addr,     32'h0);
    repeat (12) step();
    check("A_addr_count", 32'(addr_log.size() >= 3), 32'd1);
    if (addr_log.size() >= 3) begin
      check("A_addr0", addr_log[0], 32'h0);
      check("A_addr1", addr_log[1], 32'h4);
      check("A_addr2", addr_log[2], 32'h8);
    end
    check("A_vld_count", 32'(vld_pc4.size()), 32'd3);
    if (vld_pc4.size() >= 3) begin
      check("A_pc4_0", vld_pc4[0], 32'h4);
      check("A_pc4_1", vld_pc4[1], 32'h8);
      check("A_pc4_2", vld_pc4[2], 32'hC);
      check("A_latency", 32'(vld_cyc[0] - rel_cyc), 32'd3);
    end
    check("W_count", 32'(w_addr_log.size() >= 2 && w_pc4_log.size() >= 1), 32'd1);
    if (w_addr_log.size() >= 2 && w_pc4_log.size() >= 1) begin
      check("W_addr0", w_addr_log[0], 32'hFFFF_FFFC);
      check("W_pc4_0", w_pc4_log[0],  32'h0);
      check("W_addr1", w_addr_log[1], 32'h0);
    end

    // B: word buffered, both stalls held three cycles, then released.
    do_reset();
    rst = 1'b0;
    #1;
    n = 0;
    while (FetchBusy !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    check("B_reach_full", 32'(FetchBusy), 32'd0);
    StallF = 1'b1; StallD = 1'b1;
    repeat (3) begin
      step();
      check("B_hold_PCF",    PCF,             32'h0);
      check("B_hold_ValidD", 32'(ValidD),     32'd0);
      check("B_hold_InstrD", InstrD,          32'h0);
      check("B_hold_full",   32'(FetchBusy),  32'd0);
    end
    StallF = 1'b0; StallD = 1'b0;
    step();
    check("B_rel_ValidD", 32'(ValidD), 32'd1);
    check("B_rel_InstrD", InstrD,      32'h2408_0005);
    check("B_rel_pc4",    PCPlus4D,    32'h4);
    check("B_rel_PCF",    PCF,         32'h4);

    // C: redirect while waiting on PC 0x10, reply two cycles later is dropped.
    lat = 3;
    do_reset();
    rst = 1'b0;
    #1;
    n = 0;
    while (!(inst_req === 1'b1 && inst_addr === 32'h10) && n < 60) begin
      step();
      n++;
    end
    check("C_reach_0x10", inst_addr, 32'h10);
    step();
    PCSrcD = 1'b1; PCBranchD = 32'h40;
    step();
    PCSrcD = 1'b0;
    check("C_PCF_target", PCF,           32'h40);
    check("C_vld0",       32'(ValidD),   32'd0);
    check("C_no_req",     32'(inst_req), 32'd0);
    step();
    check("C_vld1",       32'(ValidD),   32'd0);
    step();
    check("C_req",        32'(inst_req), 32'd1);
    check("C_addr",       inst_addr,     32'h40);
    check("C_vld2",       32'(ValidD),   32'd0);

    // D: PCSrcD under StallD must not redirect.
    step();
    PCSrcD = 1'b1; StallD = 1'b1; PCBranchD = 32'h80;
    step();
    PCSrcD = 1'b0; StallD = 1'b0;
    check("D_PCF_kept", PCF, 32'h40);
    wait_valid("D_valid");
    check("D_pc4",   PCPlus4D, 32'h44);
    check("D_instr", InstrD,   32'h2408_4005);

    // E: reset while a reply is outstanding; reply lands during reset.
    lat = 3;
    do_reset();
    rst = 1'b0;
    #1;
    step();
    rst = 1'b1;
    repeat (4) begin
      step();
      check("E_vld_rst", 32'(ValidD), 32'd0);
    end
    rst = 1'b0;
    #1;
    check("E_req",  32'(inst_req), 32'd1);
    check("E_addr", inst_addr,     32'h0);
    wait_valid("E_valid");
    check("E_pc4",   PCPlus4D, 32'h4);
    check("E_instr", InstrD,   32'h2408_0005);

    // F: mixed stalls and redirects, checked by the model each cycle.
    do_reset();
    rst = 1'b0;
    for (int i = 0; i < 80; i++) begin
      lat       = 1 + (i % 2);
      StallF    = (i % 7 == 3);
      StallD    = (i % 5 == 2);
      PCSrcD    = (i % 11 == 6) || (i % 13 == 1);
      PCBranchD = (i % 22 == 6) ? 32'hFFFF_FFF8 : 32'h100 + 32'(i * 8);
      step();
    end
    StallF = 1'b0; StallD = 1'b0; PCSrcD = 1'b0;
    repeat (10) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
